prll_bs_rr_sched: RTL and testbench
===================================

Name: prll_bs_rr_sched

Overview:
- Round-robin scheduler and controller for one parallel bus shared by `drvrs` driver FIFO pairs.
- Polls each driver's pending flag and pops one packet from the granted driver.
- Decodes the destination ID from the packet's upper bits, then pushes the packet to the destination driver, or to every other driver on broadcast.
- Sits between the driver FIFO interfaces and the bus datapath; it is the sequencing/arbitration core for one bus.

Parameters:
- drvrs, 4, number of drivers on the bus (2..16).
- bits, 32, packet width.
- id_w, 8, destination-ID field width; field is D[bits-1 -: id_w].
- broadcast, {8{1'b1}}, ID value meaning "all drivers except source".

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- pndng  in  drvrs  bit i high = driver i FIFO non-empty; data valid on D_pop (first-word-fall-through).
- D_pop  in  drvrs*bits  flattened; driver i data at [i*bits +: bits].
- pop  out  drvrs  one-hot, one-cycle pop strobe to granted driver.
- push  out  drvrs  per-driver push strobe.
- D_push  out  bits  packet data, common to all drivers, qualified by push.
- busy  out  1  high when FSM is not in IDLE.
- grant_id  out  $clog2(drvrs)  index of current/last granted driver.
- pkt_cnt  out  16  delivered-packet counter; wraps at 0xFFFF->0.
- drop_err  out  1  one-cycle pulse when a packet is dropped for an invalid destination.

Behaviour:
Reset (reset==0 at a rising edge):
- FSM goes to IDLE.
- pop, push, D_push, busy, drop_err, pkt_cnt, grant_id all go to 0.
- Round-robin pointer last goes to drvrs-1, so driver 0 has first priority.
- Reset mid-operation discards any captured packet. A packet already popped is lost; this is accepted.

FSM states: IDLE, POP, XFER.

IDLE:
- If pndng != 0, select the first i with pndng[i]==1, searching last+1, last+2, ... modulo drvrs.
- Register grant_id = i and last = i, then go to POP.
- Otherwise stay in IDLE.

POP:
- If pndng[grant_id]==1: assert pop[grant_id] for exactly this cycle, capture D_pop[grant_id] into the packet register, go to XFER.
- If pndng[grant_id]==0 (defensive): no pop, return to IDLE; last is unchanged.

XFER: let dst = packet[bits-1 -: id_w].
- If dst==broadcast: push[j]=1 for all j != grant_id.
- Else if dst < drvrs: push[dst]=1. Loopback is allowed: dst==grant_id pushes back to the source.
- Else: no push, drop_err=1 for this cycle.
- D_push = packet this cycle.
- pkt_cnt increments by 1 when any push occurs (broadcast counts once).
- Next state is IDLE.

Timing and output rules:
- Latency: pndng sampled high in IDLE at cycle t -> pop at t+1 -> push at t+2.
- Throughput is one packet per 3 cycles.
- All outputs are registered. pop and push are never high in the same cycle.
- Fairness: with all pndng high continuously, grants cycle 0,1,2,...,drvrs-1,0,...
- No driver waits more than drvrs grants.
- pndng changes during POP/XFER do not affect the current transfer. They are sampled only in IDLE, plus the single check of pndng[grant_id] in POP.
- D_push holds its last value outside XFER. It is don't-care to consumers while push==0.

Decomposition:
- Package prll_bs_pkg: FSM state enum (IDLE/POP/XFER), localparam GW=$clog2(drvrs), and a function extracting the dest ID.
- One sub-module: prll_bs_rr_pick, a combinational round-robin priority picker.
  - Inputs: req[drvrs], last[GW].
  - Outputs: gnt_idx[GW], any.

Test Plan:
- Reset hold: reset=0 for 3 cycles with pndng=4'b1111 -> pop=0, push=0, pkt_cnt=0, busy=0 throughout; after release, first grant_id=0.
- Unicast: drvr 1 pndng with D=0x02_00ABCD -> pop=4'b0010 at t+1; push=4'b0100 and D_push=0x0200ABCD at t+2; pkt_cnt=1.
- Broadcast: drvr 2 sends 0xFF_001234 -> push=4'b1011 for one cycle; pkt_cnt increments by 1.
- Fairness: pndng=4'b1111 held for 12 packets -> grant order 0,1,2,3,0,1,2,3,0,1,2,3.
- Invalid destination: drvr 0 sends 0x07_000000 with drvrs=4 -> pop=4'b0001, then push=0 and drop_err=1 for one cycle; pkt_cnt unchanged.
- Reset mid-transfer: reset=0 asserted in the POP-cycle edge -> next cycle FSM in IDLE, push never asserted; pkt_cnt=0.

Source files
------------

// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared FSM state type, default sizing and destination-ID extraction
// Default config: 4 drivers, 32-bit packets, 8-bit destination field in the top bits.
package prll_bs_pkg;
  localparam int DRVRS = 4;
  localparam int BITS = 32;
  localparam int ID_W = 8;
  localparam int GW = $clog2(DRVRS);
  typedef enum logic [1:0] {IDLE, POP, XFER} state_e;
  // Packets up to 64 bits wide; returns the id_w-bit field ending at bit bits-1.
  function automatic logic [31:0] dest_id(input logic [63:0] pkt, input int bits, input int id_w);
    logic [63:0] m;
    m = (64'd1 << id_w) - 64'd1;
    return 32'((pkt >> (bits - id_w)) & m);
  endfunction
endpackage

// File: rtl/prll_bs_rr_pick.sv
// prll_bs_rr_pick: combinational round-robin picker, first request after last (mod n)
// Ports: req (request vector), last (previous winner), gnt_idx (winner index), any (some request set).
module prll_bs_rr_pick #(
  parameter int n = 4,
  parameter int gw = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [gw-1:0] last,
  output logic [gw-1:0] gnt_idx,
  output logic          any
);
  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    gnt_idx = '0;
    for (int k = n; k >= 1; k--)
      if (req[(int'(last) + k) % n]) gnt_idx = gw'((int'(last) + k) % n);
    any = |req;
  end
endmodule

// File: rtl/prll_bs_rr_sched.sv
// prll_bs_rr_sched: round-robin pop/decode/push sequencer for one shared parallel bus
// Ports: clk, reset (sync, active-low), pndng/D_pop (driver FIFO status and FWFT data),
// pop/push/D_push (driver strobes and data), busy, grant_id, pkt_cnt, drop_err (status).
module prll_bs_rr_sched
  import prll_bs_pkg::*;
#(
  parameter int drvrs = DRVRS,
  parameter int bits = BITS,
  parameter int id_w = ID_W,
  parameter logic [id_w-1:0] broadcast = '1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [drvrs-1:0]          pndng,
  input  logic [drvrs*bits-1:0]     D_pop,
  output logic [drvrs-1:0]          pop,
  output logic [drvrs-1:0]          push,
  output logic [bits-1:0]           D_push,
  output logic                      busy,
  output logic [$clog2(drvrs)-1:0]  grant_id,
  output logic [15:0]               pkt_cnt,
  output logic                      drop_err
);
  localparam int gw = $clog2(drvrs);
  state_e            state_q;
  logic [gw-1:0]     last_q, pick;
  logic [bits-1:0]   pkt_q;
  logic [id_w-1:0]   dst;
  logic [drvrs-1:0]  one, push_d;
  logic              any, drop_d;
  prll_bs_rr_pick #(.n(drvrs), .gw(gw)) u_pick (.req(pndng), .last(last_q), .gnt_idx(pick), .any(any));
  assign one = drvrs'(1);
  assign dst = id_w'(dest_id(64'(pkt_q), bits, id_w));
  // Broadcast goes to everyone but the source; unicast may loop back to the source.
  always_comb begin
    push_d = dst == broadcast ? ~(one << grant_id) : 32'(dst) < drvrs ? one << dst : '0;
    drop_d = dst != broadcast && 32'(dst) >= drvrs;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= gw'(drvrs - 1);
      pkt_q    <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      pkt_cnt  <= '0;
      drop_err <= 1'b0;
    end else begin
      pop      <= '0;
      push     <= '0;
      drop_err <= 1'b0;
      case (state_q)
        IDLE: if (any) begin
          grant_id <= pick;
          last_q   <= pick;
          busy     <= 1'b1;
          state_q  <= POP;
        end
        POP: if (pndng[grant_id]) begin
          pop     <= one << grant_id;
          pkt_q   <= D_pop[grant_id*bits +: bits];
          state_q <= XFER;
        end else begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          push     <= push_d;
          D_push   <= pkt_q;
          drop_err <= drop_d;
          pkt_cnt  <= pkt_cnt + 16'(|push_d);
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prll_bs_rr_sched.sv
// tb_prll_bs_rr_sched: directed self-checking bench for prll_bs_rr_sched (4 drivers, 32-bit)
module tb_prll_bs_rr_sched;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   pndng = '0;
  logic [127:0] d_pop = '0;
  logic [3:0]   pop, push;
  logic [31:0]  d_push;
  logic         busy, drop_err;
  logic [1:0]   grant_id;
  logic [15:0]  pkt_cnt;
  int checks = 0;
  int failures = 0;
  prll_bs_rr_sched dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop), .push(push),
    .D_push(d_push), .busy(busy), .grant_id(grant_id), .pkt_cnt(pkt_cnt), .drop_err(drop_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    pndng = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    pndng = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pop !== 4'b0) begin failures++; $display("FAIL rst_pop got=%b exp=0000", pop); end
      checks++; if (push !== 4'b0) begin failures++; $display("FAIL rst_push got=%b exp=0000", push); end
      checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", pkt_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    end
    checks++; if (d_push !== 32'h0 || drop_err !== 1'b0) begin failures++; $display("FAIL rst_dpush got=%h/%b exp=0/0", d_push, drop_err); end
    reset = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_first_grant got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy_pop got=%b exp=1", busy); end
    // Withdraw the request before the POP edge: no pop, back to IDLE.
    pndng = '0;
    tick();
    checks++; if (pop !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL defensive_pop got=%b/%b exp=0000/0", pop, busy); end
    tick();
    checks++; if (push !== 4'b0) begin failures++; $display("FAIL defensive_push got=%b exp=0000", push); end
  endtask
  task automatic test_unicast();
    do_reset();
    d_pop[32 +: 32] = 32'h0200ABCD;
    pndng = 4'b0010;
    tick();
    checks++; if (grant_id !== 2'd1 || pop !== 4'b0) begin failures++; $display("FAIL uni_grant got=%0d/%b exp=1/0000", grant_id, pop); end
    tick();
    checks++; if (pop !== 4'b0010 || push !== 4'b0) begin failures++; $display("FAIL uni_pop got=%b/%b exp=0010/0000", pop, push); end
    pndng = '0;
    tick();
    checks++; if (push !== 4'b0100 || pop !== 4'b0) begin failures++; $display("FAIL uni_push got=%b/%b exp=0100/0000", push, pop); end
    checks++; if (d_push !== 32'h0200ABCD) begin failures++; $display("FAIL uni_data got=%h exp=0200abcd", d_push); end
    checks++; if (pkt_cnt !== 16'd1) begin failures++; $display("FAIL uni_cnt got=%0d exp=1", pkt_cnt); end
    tick();
    checks++; if (push !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL uni_after got=%b/%b exp=0000/0", push, busy); end
    checks++; if (d_push !== 32'h0200ABCD) begin failures++; $display("FAIL uni_hold got=%h exp=0200abcd", d_push); end
  endtask
  task automatic test_broadcast();
    do_reset();
    d_pop[64 +: 32] = 32'hFF001234;
    pndng = 4'b0100;
    tick();
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL bc_grant got=%0d exp=2", grant_id); end
    tick();
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL bc_pop got=%b exp=0100", pop); end
    pndng = '0;
    tick();
    checks++; if (push !== 4'b1011 || d_push !== 32'hFF001234) begin failures++; $display("FAIL bc_push got=%b/%h exp=1011/ff001234", push, d_push); end
    checks++; if (pkt_cnt !== 16'd1) begin failures++; $display("FAIL bc_cnt got=%0d exp=1", pkt_cnt); end
    tick();
    checks++; if (push !== 4'b0) begin failures++; $display("FAIL bc_once got=%b exp=0000", push); end
  endtask
  task automatic test_loopback();
    do_reset();
    d_pop[96 +: 32] = 32'h03C0FFEE;
    pndng = 4'b1000;
    tick();
    tick();
    pndng = '0;
    tick();
    checks++; if (push !== 4'b1000 || drop_err !== 1'b0) begin failures++; $display("FAIL loop_push got=%b/%b exp=1000/0", push, drop_err); end
    tick();
  endtask
  task automatic test_fairness();
    logic [3:0] exp_pop, exp_push;
    do_reset();
    for (int i = 0; i < 4; i++) d_pop[i*32 +: 32] = {8'((i + 1) % 4), 24'(i)};
    pndng = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      exp_pop = 4'b0001 << (k % 4);
      exp_push = 4'b0001 << ((k + 1) % 4);
      tick();
      checks++; if (grant_id !== 2'(k % 4)) begin failures++; $display("FAIL fair_grant k=%0d got=%0d exp=%0d", k, grant_id, k % 4); end
      tick();
      checks++; if (pop !== exp_pop || push !== 4'b0) begin failures++; $display("FAIL fair_pop k=%0d got=%b/%b exp=%b/0000", k, pop, push, exp_pop); end
      tick();
      checks++; if (push !== exp_push || pop !== 4'b0) begin failures++; $display("FAIL fair_push k=%0d got=%b/%b exp=%b/0000", k, push, pop, exp_push); end
    end
    checks++; if (pkt_cnt !== 16'd12) begin failures++; $display("FAIL fair_cnt got=%0d exp=12", pkt_cnt); end
    pndng = '0;
    tick();
  endtask
  task automatic test_invalid();
    do_reset();
    d_pop[0 +: 32] = 32'h07000000;
    pndng = 4'b0001;
    tick();
    tick();
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL inv_pop got=%b exp=0001", pop); end
    pndng = '0;
    tick();
    checks++; if (push !== 4'b0 || drop_err !== 1'b1) begin failures++; $display("FAIL inv_drop got=%b/%b exp=0000/1", push, drop_err); end
    checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL inv_cnt got=%0d exp=0", pkt_cnt); end
    tick();
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL inv_pulse got=%b exp=0", drop_err); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    d_pop[32 +: 32] = 32'h0200ABCD;
    pndng = 4'b0010;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL mid_idle got=%b/%b/%b exp=0/0000/0000", busy, pop, push); end
    reset = 1'b1;
    pndng = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (push !== 4'b0 || pkt_cnt !== 16'd0) begin failures++; $display("FAIL mid_nopush got=%b/%0d exp=0000/0", push, pkt_cnt); end
    end
  endtask
  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_loopback();
    test_fairness();
    test_invalid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
